// File: rtl/adc_bridge_pkg.sv
// Shared constants and FSM state type for the ADC bridge host sequencer.
package adc_bridge_pkg;

  localparam int unsigned CFG_BITS    = 33;
  localparam int unsigned FRAME_BITS  = 20;
  localparam logic [1:0]  FRAME_HEAD  = 2'b10;
  localparam logic [1:0]  FRAME_TAIL  = 2'b01;
  localparam int unsigned BRST_CYCLES = 2;

  typedef enum logic [2:0] {
    StBrst,
    StIdle,
    StCfgShift,
    StCfgLoad,
    StWaitConv,
    StResLoad,
    StResShift,
    StCheck
  } state_e;

endpackage

// File: rtl/adc_sync_rise.sv
// Multi-stage synchroniser with a rising-edge detector whose history can be seeded.
module adc_sync_rise #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  input  logic seed,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      // Seeding loads the level that becomes current next cycle, so a level
      // already high on entry never looks like an edge.
      prev_q <= seed ? sync_q[SYNC_STAGES-2] : sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/adc_bridge_seq.sv
// Host sequencer: resets and configures the serial ADC bridge, then reads and
// frame-checks conversion results.
module adc_bridge_seq
  import adc_bridge_pkg::*;
#(
  parameter int unsigned          SYNC_STAGES = 2,
  parameter int unsigned          TIMEOUT_W   = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cont,
  input  logic        reconfig,
  input  logic [15:0] cfg1,
  input  logic [15:0] cfg2,
  input  logic        cfg_sel,
  output logic        br_rst_n,
  output logic        br_dat_o,
  output logic        br_load,
  input  logic        br_dat_i,
  input  logic        br_conv_finish,
  output logic [15:0] res_data,
  output logic        res_valid,
  output logic        frame_err,
  output logic        timeout,
  output logic        busy,
  output logic        cfg_done
);

  localparam logic [TIMEOUT_W-1:0] ToLast = TIMEOUT - 1'b1;

  state_e                  state_q, state_d;
  logic [5:0]              bit_cnt_q, bit_cnt_d;
  logic [TIMEOUT_W-1:0]    to_cnt_q, to_cnt_d;
  logic [CFG_BITS-1:0]     cfg_sr_q, cfg_sr_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic                    br_rst_n_q, br_rst_n_d;
  logic                    br_dat_o_q, br_dat_o_d;
  logic                    br_load_q, br_load_d;
  logic [15:0]             res_data_q, res_data_d;
  logic                    res_valid_q, res_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic                    timeout_q, timeout_d;
  logic                    busy_q, busy_d;
  logic                    cfg_done_q, cfg_done_d;
  logic                    fin_rise, fin_seed, frame_good;

  assign fin_seed = (state_q != StWaitConv);

  adc_sync_rise #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_rise (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(br_conv_finish),
    .seed    (fin_seed),
    .rise    (fin_rise)
  );

  assign frame_good = (frame_q[1:0] == FRAME_TAIL) &&
                      (frame_q[FRAME_BITS-1 -: 2] == FRAME_HEAD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StBrst;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      cfg_sr_q    <= '0;
      frame_q     <= '0;
      br_rst_n_q  <= 1'b0;
      br_dat_o_q  <= 1'b0;
      br_load_q   <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b1;
      cfg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      cfg_sr_q    <= cfg_sr_d;
      frame_q     <= frame_d;
      br_rst_n_q  <= br_rst_n_d;
      br_dat_o_q  <= br_dat_o_d;
      br_load_q   <= br_load_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      cfg_done_q  <= cfg_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    cfg_sr_d  = cfg_sr_q;
    frame_d   = frame_q;
    unique case (state_q)
      StBrst: begin
        if (bit_cnt_q == 6'(BRST_CYCLES - 1)) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      StIdle: begin
        if (reconfig) begin
          state_d   = StBrst;
          bit_cnt_d = '0;
        end else if (start && !cfg_done_q) begin
          state_d   = StCfgShift;
          bit_cnt_d = '0;
          cfg_sr_d  = {cfg_sel, cfg2, cfg1};
        end else if (start) begin
          state_d  = StWaitConv;
          to_cnt_d = '0;
        end
      end
      StCfgShift: begin
        cfg_sr_d = cfg_sr_q >> 1;
        if (bit_cnt_q == 6'(CFG_BITS - 1)) begin
          state_d = StCfgLoad;
        end else begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      StCfgLoad: begin
        state_d  = StWaitConv;
        to_cnt_d = '0;
      end
      StWaitConv: begin
        if (fin_rise) begin
          state_d = StResLoad;
        end else if (to_cnt_q == ToLast) begin
          state_d = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StResLoad: begin
        state_d   = StResShift;
        bit_cnt_d = '0;
      end
      StResShift: begin
        frame_d = {br_dat_i, frame_q[FRAME_BITS-1:1]};
        if (bit_cnt_q == 6'(FRAME_BITS - 1)) begin
          state_d = StCheck;
        end else begin
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
      StCheck: begin
        state_d  = cont ? StWaitConv : StIdle;
        to_cnt_d = '0;
      end
      default: state_d = StBrst;
    endcase
  end

  // Outputs are registered from the state being entered, so they line up with it.
  always_comb begin
    br_rst_n_d  = (state_d != StBrst);
    busy_d      = (state_d != StIdle);
    br_load_d   = (state_d == StCfgLoad) || (state_d == StResLoad);
    br_dat_o_d  = (state_d == StCfgShift) && cfg_sr_d[0];
    res_valid_d = (state_q == StCheck) && frame_good;
    frame_err_d = (state_q == StCheck) && !frame_good;
    res_data_d  = res_valid_d ? frame_q[FRAME_BITS-3:2] : res_data_q;
    timeout_d   = (state_q == StWaitConv) && !fin_rise && (to_cnt_q == ToLast);
    cfg_done_d  = cfg_done_q;
    if (state_d == StBrst) begin
      cfg_done_d = 1'b0;
    end else if (state_q == StCfgLoad) begin
      cfg_done_d = 1'b1;
    end
  end

  assign br_rst_n  = br_rst_n_q;
  assign br_dat_o  = br_dat_o_q;
  assign br_load   = br_load_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign frame_err = frame_err_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;
  assign cfg_done  = cfg_done_q;

endmodule

// File: tb/tb_adc_bridge_seq.sv
// Directed bench for adc_bridge_seq with a small behavioural bridge model.
module tb_adc_bridge_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cont, reconfig, cfg_sel;
  logic [15:0] cfg1, cfg2;
  logic        br_rst_n, br_dat_o, br_load, br_dat_i, br_conv_finish;
  logic [15:0] res_data;
  logic        res_valid, frame_err, timeout, busy, cfg_done;

  int checks   = 0;
  int failures = 0;

  logic [19:0] br_frame = '0;
  logic [19:0] br_sr    = '0;

  always #5 clk = ~clk;

  adc_bridge_seq #(
    .SYNC_STAGES(2),
    .TIMEOUT_W  (16),
    .TIMEOUT    (16'd8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cont          (cont),
    .reconfig      (reconfig),
    .cfg1          (cfg1),
    .cfg2          (cfg2),
    .cfg_sel       (cfg_sel),
    .br_rst_n      (br_rst_n),
    .br_dat_o      (br_dat_o),
    .br_load       (br_load),
    .br_dat_i      (br_dat_i),
    .br_conv_finish(br_conv_finish),
    .res_data      (res_data),
    .res_valid     (res_valid),
    .frame_err     (frame_err),
    .timeout       (timeout),
    .busy          (busy),
    .cfg_done      (cfg_done)
  );

  // Bridge: captures its frame on a load strobe, then presents it LSB first.
  always @(posedge clk) begin
    if (br_load) br_sr <= br_frame;
    else         br_sr <= {1'b0, br_sr[19:1]};
  end
  assign br_dat_i = br_sr[0];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Collects 33 serial config bits; inputs are disturbed mid-stream.
  task automatic shift_cfg(output logic [32:0] got, output int loads);
    loads = 0;
    for (int k = 0; k < 33; k++) begin
      got[k] = br_dat_o;
      if (br_load) loads++;
      if (k == 3) begin
        cfg1    = ~cfg1;
        cfg2    = ~cfg2;
        cfg_sel = ~cfg_sel;
      end
      tick();
    end
  endtask

  // Counts posedges until a result/error/timeout pulse; n stays -1 if none.
  task automatic wait_event(input int drop_at, output int n, output int loads);
    int i;
    n = -1;
    loads = 0;
    i = 0;
    while (n < 0 && i < 60) begin
      i++;
      tick();
      if (i == drop_at) br_conv_finish = 1'b0;
      if (br_load) loads++;
      if (res_valid || frame_err || timeout) n = i;
    end
  endtask

  logic [32:0] got;
  int          n, loads;
  logic [15:0] dat3 [3];

  initial begin
    dat3 = '{16'h1111, 16'h2222, 16'h3333};
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; reconfig = 1'b0;
    cfg1 = '0; cfg2 = '0; cfg_sel = 1'b0; br_conv_finish = 1'b0;
    tick();
    tick();
    chk("rst_br_rst_n", br_rst_n, 0);
    chk("rst_busy", busy, 1);
    chk("rst_cfg_done", cfg_done, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_pulses", {res_valid, frame_err, timeout, br_load, br_dat_o}, 0);

    rst_n = 1'b1;
    tick();
    chk("brst_hold", br_rst_n, 0);
    tick();
    chk("brst_release", br_rst_n, 1);
    chk("idle_busy", busy, 0);

    // First config load
    cfg1 = 16'hA5C3; cfg2 = 16'h0F01; cfg_sel = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("shift_busy", busy, 1);
    chk("shift_cfg_done", cfg_done, 0);
    shift_cfg(got, loads);
    chk("cfg_stream", got, 33'h1_0F01_A5C3);
    chk("cfg_no_early_load", loads, 0);
    chk("cfg_load", br_load, 1);
    chk("cfg_load_dat", br_dat_o, 0);
    tick();
    chk("wait_load_low", br_load, 0);
    chk("cfg_done_set", cfg_done, 1);

    // Good frame
    br_frame = {2'b10, 16'h1234, 2'b01};
    br_conv_finish = 1'b1;
    wait_event(5, n, loads);
    chk("good_latency", n, 25);
    chk("good_loads", loads, 1);
    chk("good_valid", res_valid, 1);
    chk("good_ferr", frame_err, 0);
    chk("good_data", res_data, 16'h1234);
    tick();
    chk("valid_pulse", res_valid, 0);
    chk("back_idle", busy, 0);

    // Corrupt head bit 19
    br_frame = {2'b00, 16'hBEEF, 2'b01};
    start = 1'b1;
    tick();
    start = 1'b0;
    br_conv_finish = 1'b1;
    wait_event(5, n, loads);
    chk("bad_latency", n, 25);
    chk("bad_ferr", frame_err, 1);
    chk("bad_no_valid", res_valid, 0);
    chk("bad_data_kept", res_data, 16'h1234);
    tick();
    chk("ferr_pulse", frame_err, 0);

    // Finish already high on entry must not trigger; timeout instead
    br_conv_finish = 1'b1;
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_event(0, n, loads);
    chk("to_latency", n, 8);
    chk("to_pulse", timeout, 1);
    chk("to_no_valid", res_valid, 0);
    chk("to_idle", busy, 0);
    tick();
    chk("to_pulse_end", timeout, 0);

    // Continuous mode, three results without reconfiguration
    br_conv_finish = 1'b0;
    cont = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      br_frame = {2'b10, dat3[j], 2'b01};
      br_conv_finish = 1'b1;
      wait_event(5, n, loads);
      chk("cont_latency", n, 25);
      chk("cont_valid", res_valid, 1);
      chk("cont_data", res_data, dat3[j]);
      chk("cont_single_load", loads, 1);
      chk("cont_busy", busy, 1);
      chk("cont_cfg_done", cfg_done, 1);
    end
    cont = 1'b0;
    wait_event(0, n, loads);
    chk("cont_exit_timeout", n, 8);
    chk("cont_exit_idle", busy, 0);

    // Reconfig has priority over start
    reconfig = 1'b1;
    start = 1'b1;
    tick();
    reconfig = 1'b0;
    start = 1'b0;
    chk("rcfg_rst0", br_rst_n, 0);
    chk("rcfg_cfg_done", cfg_done, 0);
    chk("rcfg_busy", busy, 1);
    tick();
    chk("rcfg_rst1", br_rst_n, 0);
    tick();
    chk("rcfg_release", br_rst_n, 1);
    chk("rcfg_idle", busy, 0);
    chk("rcfg_cfg_done_idle", cfg_done, 0);
    cfg1 = 16'h8001; cfg2 = 16'h7FFE; cfg_sel = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    shift_cfg(got, loads);
    chk("recfg_stream", got, {1'b0, 16'h7FFE, 16'h8001});
    chk("recfg_load", br_load, 1);
    tick();
    chk("recfg_done", cfg_done, 1);

    // Reset during RES_SHIFT cycle 7
    br_frame = {2'b10, 16'h5555, 2'b01};
    br_conv_finish = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_data", res_data, 16'h3333);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_br_rst_n", br_rst_n, 0);
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_cfg_done", cfg_done, 0);
    chk("mid_rst_data", res_data, 0);
    chk("mid_rst_pulses", {res_valid, frame_err, timeout, br_load, br_dat_o}, 0);
    rst_n = 1'b1;
    br_conv_finish = 1'b0;
    tick();
    tick();
    chk("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_bridge_seq.md
Name: adc_bridge_seq

Overview:
Host-side sequencer that drives the serial ADC bridge, clocked on the same clk as the bridge.
- Shifts the 33-bit ADC config into the bridge and issues the load strobe.
- Waits for conversion finish and captures the 20-bit framed result.
- Checks the framing and presents a parallel 16-bit result with a valid pulse.
- Owns the bridge reset, so it can force a reconfiguration (the bridge accepts config once per reset).

Parameters:
SYNC_STAGES, 2, synchroniser depth on br_conv_finish (minimum 2)
TIMEOUT_W, 16, width of the conversion-wait timeout counter
TIMEOUT, 16'hFFFF, cycles in WAIT_CONV before abort (minimum 1)

Ports:
clk  in  1  clock; also drives the bridge clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  request one conversion readout; sampled only in IDLE
cont  in  1  continuous mode: after each result return to WAIT_CONV instead of IDLE
reconfig  in  1  request bridge re-reset and config reload; sampled only in IDLE
cfg1  in  16  ADC config word 1
cfg2  in  16  ADC config word 2
cfg_sel  in  1  conv_finish select bit (config bit 32)
br_rst_n  out  1  bridge async reset, registered
br_dat_o  out  1  serial config to bridge dat_i
br_load  out  1  bridge load strobe
br_dat_i  in  1  serial result from bridge dat_o
br_conv_finish  in  1  bridge conv_finish, asynchronous to clk
res_data  out  16  last good result
res_valid  out  1  one-cycle pulse: res_data updated
frame_err  out  1  one-cycle pulse: framing mismatch; res_data not updated
timeout  out  1  one-cycle pulse: WAIT_CONV timeout
busy  out  1  high in every state except IDLE
cfg_done  out  1  bridge holds the current config

Behaviour:
- Reset (rst_n=0 at a posedge) values:
  - state=BRST; br_rst_n=0, br_load=0, br_dat_o=0.
  - res_data=0; res_valid=0, frame_err=0, timeout=0.
  - cfg_done=0; busy=1 (state BRST).
  - Synchroniser, edge register and all counters cleared.
- Reset mid-operation: same values, at the next posedge with rst_n=0.
- All outputs are registered.
- BRST: hold br_rst_n=0 for 2 cycles, then br_rst_n=1, cfg_done=0, go to IDLE.
- IDLE:
  - reconfig=1 → BRST. reconfig has priority over start.
  - Else start=1 and cfg_done=0 → CFG_SHIFT.
  - Else start=1 and cfg_done=1 → WAIT_CONV.
  - Otherwise hold.
- CFG_SHIFT: 33 cycles with br_load=0.
  - br_dat_o presents bit k in cycle k, LSB first.
  - Bit order: cfg1[0..15], then cfg2[0..15], then cfg_sel last.
  - cfg1/cfg2/cfg_sel are latched into a 33-bit shift register on leaving IDLE; input changes during the sequence are ignored.
- CFG_LOAD: one cycle br_load=1, br_dat_o=0. Set cfg_done=1, go to WAIT_CONV.
- WAIT_CONV:
  - br_load=0, br_dat_o=0.
  - On entry, seed the edge register with the current synchronised level; an already-high finish does not trigger.
  - A rising edge of the synchronised finish → RES_LOAD.
  - Counter counts from 0; reaching TIMEOUT-1 without an edge → pulse timeout, go to IDLE (cont is ignored).
  - An edge in the same cycle as the timeout wins; no timeout is reported.
- RES_LOAD: one cycle br_load=1; the bridge captures its frame. Next state RES_SHIFT.
- RES_SHIFT: 20 cycles with br_load=0, br_dat_o=0.
  - Sample br_dat_i at each posedge into frame[i], i=0..19.
  - frame[0] is available the cycle after RES_LOAD.
- CHECK: one cycle.
  - Frame is good when frame[1:0]=2'b01 and frame[19:18]=2'b10.
  - Good: res_data<=frame[17:2], pulse res_valid.
  - Bad: pulse frame_err, res_data unchanged.
  - Next state: cont=1 → WAIT_CONV, else IDLE.
- Latency: start (cfg_done=0) to entering WAIT_CONV = 34 cycles. Finish edge to res_valid = SYNC_STAGES + 1 (edge detect) + 1 (RES_LOAD) + 20 + 1 cycles.
- Bit counters are 6 bits; neither wraps, each terminates at count 32 or 19.
- start/reconfig outside IDLE are ignored; no queuing.

Decomposition:
- Package adc_bridge_pkg:
  - CFG_BITS=33, FRAME_BITS=20.
  - FRAME_HEAD=2'b10, FRAME_TAIL=2'b01.
  - BRST_CYCLES=2.
  - State enum: BRST, IDLE, CFG_SHIFT, CFG_LOAD, WAIT_CONV, RES_LOAD, RES_SHIFT, CHECK.
- Sub-module adc_sync_rise: SYNC_STAGES-deep synchroniser plus rising-edge detector with a seed/clear input.

Test Plan:
- Reset release, start, cfg1=16'hA5C3, cfg2=16'h0F01, cfg_sel=1 → br_dat_o stream over 33 cycles equals 33'h1_0F01_A5C3 LSB first, then one br_load cycle; cfg_done=1.
- Bridge model returns adc_res=16'h1234 after finish edge → br_load pulse, 20 samples, res_valid pulse with res_data=16'h1234 at the specified latency.
- Corrupt frame bit 19 to 0 → frame_err pulse, res_data keeps its previous value, no res_valid.
- No finish edge with TIMEOUT=8 → timeout pulse 8 cycles after WAIT_CONV entry, state IDLE; finish already high at entry → no trigger.
- cont=1 with three finish edges → three res_valid pulses, no further config shifting; then reconfig → br_rst_n low 2 cycles, cfg_done=0, next start reshifts config.
- rst_n=0 during RES_SHIFT cycle 7 → next cycle all outputs at reset values, br_rst_n=0.
